// File: rtl/hazard_scoreboard_pkg.sv
// Shared datapath widths and operand-source types for the hazard scoreboard slice.
package hazard_scoreboard_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xdata_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SRC_RF,
    SRC_PIPE,
    SRC_CMPL
  } fwd_src_e;

endpackage

// File: rtl/hazard_scoreboard_fwd_mux.sv
// One operand read port: priority forwarding select plus RAW hazard flag.
module fwd_mux
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [REG_ADDR_W-1:0]         rd_addr,
  input  logic [XLEN-1:0]               rd_val_in,
  input  logic [NUM_FWD-1:0]            fwd_wb_en,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]            fwd_data_ok,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic                          cmpl_valid,
  input  logic [REG_ADDR_W-1:0]         cmpl_rd,
  input  logic [XLEN-1:0]               cmpl_data,
  input  logic [31:0]                   busy_map,
  output logic [XLEN-1:0]               rd_val_out,
  output logic                          hazard
);

  logic      pipe_hit;
  logic      pipe_ok;
  xdata_t    pipe_data;
  reg_addr_t src_rd;
  fwd_src_e  src;

  always_comb begin
    pipe_hit  = 1'b0;
    pipe_ok   = 1'b0;
    pipe_data = '0;
    src_rd    = '0;
    // Ascending scan with a found-guard keeps the youngest (lowest index) match.
    for (int unsigned s = 0; s < NUM_FWD; s++) begin
      src_rd = fwd_rd[s*REG_ADDR_W +: REG_ADDR_W];
      if (!pipe_hit && fwd_wb_en[s] && (src_rd != '0) && (src_rd == rd_addr)) begin
        pipe_hit  = 1'b1;
        pipe_ok   = fwd_data_ok[s];
        pipe_data = fwd_data[s*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    src = SRC_RF;
    if (rd_addr != '0) begin
      if (pipe_hit) begin
        src = SRC_PIPE;
      end else if (cmpl_valid && (cmpl_rd != '0) && (cmpl_rd == rd_addr)) begin
        src = SRC_CMPL;
      end
    end
  end

  always_comb begin
    rd_val_out = rd_val_in;
    hazard     = 1'b0;
    case (src)
      SRC_PIPE: begin
        rd_val_out = pipe_data;
        hazard     = ~pipe_ok;
      end
      SRC_CMPL: begin
        rd_val_out = cmpl_data;
        hazard     = 1'b0;
      end
      default: begin
        rd_val_out = rd_val_in;
        hazard     = (rd_addr != '0) && busy_map[rd_addr];
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand forwarding network and long-latency busy scoreboard with decode stall generation.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_RD*REG_ADDR_W-1:0]    rd_addr,
  input  logic [NUM_RD*XLEN-1:0]          rd_val_in,
  input  logic [NUM_FWD-1:0]              fwd_wb_en,
  input  logic [NUM_FWD*REG_ADDR_W-1:0]   fwd_rd,
  input  logic [NUM_FWD-1:0]              fwd_data_ok,
  input  logic [NUM_FWD*XLEN-1:0]         fwd_data,
  input  logic                            issue_valid,
  input  logic                            issue_long,
  input  logic [REG_ADDR_W-1:0]           issue_rd,
  input  logic                            cmpl_valid,
  input  logic [REG_ADDR_W-1:0]           cmpl_rd,
  input  logic [XLEN-1:0]                 cmpl_data,
  output logic [NUM_RD*XLEN-1:0]          rd_val_out,
  output logic                            stall,
  output logic [31:0]                     busy_map,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
  output logic [31:0]                     stall_cycles
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  logic [NUM_RD-1:0] port_hazard;
  logic              pend_full;
  logic              issue_set;
  logic              cmpl_clr;
  logic [31:0]       busy_nxt;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_mux #(
      .NUM_FWD (NUM_FWD)
    ) u_fwd_mux (
      .rd_addr     (rd_addr[p*REG_ADDR_W +: REG_ADDR_W]),
      .rd_val_in   (rd_val_in[p*XLEN +: XLEN]),
      .fwd_wb_en   (fwd_wb_en),
      .fwd_rd      (fwd_rd),
      .fwd_data_ok (fwd_data_ok),
      .fwd_data    (fwd_data),
      .cmpl_valid  (cmpl_valid),
      .cmpl_rd     (cmpl_rd),
      .cmpl_data   (cmpl_data),
      .busy_map    (busy_map),
      .rd_val_out  (rd_val_out[p*XLEN +: XLEN]),
      .hazard      (port_hazard[p])
    );
  end

  // A full tracker still accepts a long issue when a completion frees a slot this cycle.
  assign pend_full = (pend_cnt == PEND_W'(MAX_PEND));
  assign stall     = (|port_hazard) | (issue_valid & issue_long & pend_full & ~cmpl_valid);
  assign issue_set = issue_valid & ~stall & issue_long & (issue_rd != '0);
  assign cmpl_clr  = cmpl_valid & (pend_cnt != '0);

  // Set is applied after clear so a same-register retire-and-reissue stays busy.
  always_comb begin
    busy_nxt = busy_map;
    if (cmpl_clr) begin
      busy_nxt[cmpl_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_map     <= '0;
      pend_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      busy_map <= busy_nxt;
      case ({issue_set, cmpl_clr})
        2'b10:   pend_cnt <= pend_cnt + PEND_W'(1);
        2'b01:   pend_cnt <= pend_cnt - PEND_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a behavioural scoreboard model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NUM_RD   = 2;
  localparam int unsigned NUM_FWD  = 2;
  localparam int unsigned MAX_PEND = 4;
  localparam int unsigned PW       = $clog2(MAX_PEND + 1);

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b1;
  logic [NUM_RD*REG_ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*XLEN-1:0]        rd_val_in;
  logic [NUM_FWD-1:0]            fwd_wb_en;
  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd;
  logic [NUM_FWD-1:0]            fwd_data_ok;
  logic [NUM_FWD*XLEN-1:0]       fwd_data;
  logic                          issue_valid;
  logic                          issue_long;
  logic [REG_ADDR_W-1:0]         issue_rd;
  logic                          cmpl_valid;
  logic [REG_ADDR_W-1:0]         cmpl_rd;
  logic [XLEN-1:0]               cmpl_data;
  logic [NUM_RD*XLEN-1:0]        rd_val_out;
  logic                          stall;
  logic [31:0]                   busy_map;
  logic [PW-1:0]                 pend_cnt;
  logic [31:0]                   stall_cycles;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0]     m_busy;
  int              m_pend;
  logic [31:0]     m_stalls;
  logic [XLEN-1:0] exp_val [NUM_RD];
  logic            exp_stall;

  hazard_scoreboard #(
    .NUM_RD   (NUM_RD),
    .NUM_FWD  (NUM_FWD),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr      (rd_addr),
    .rd_val_in    (rd_val_in),
    .fwd_wb_en    (fwd_wb_en),
    .fwd_rd       (fwd_rd),
    .fwd_data_ok  (fwd_data_ok),
    .fwd_data     (fwd_data),
    .issue_valid  (issue_valid),
    .issue_long   (issue_long),
    .issue_rd     (issue_rd),
    .cmpl_valid   (cmpl_valid),
    .cmpl_rd      (cmpl_rd),
    .cmpl_data    (cmpl_data),
    .rd_val_out   (rd_val_out),
    .stall        (stall),
    .busy_map     (busy_map),
    .pend_cnt     (pend_cnt),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] out_port(input int p);
    return rd_val_out[p*XLEN +: XLEN];
  endfunction

  task automatic idle();
    rd_addr     = '0;
    rd_val_in   = '0;
    fwd_wb_en   = '0;
    fwd_rd      = '0;
    fwd_data_ok = '0;
    fwd_data    = '0;
    issue_valid = 1'b0;
    issue_long  = 1'b0;
    issue_rd    = '0;
    cmpl_valid  = 1'b0;
    cmpl_rd     = '0;
    cmpl_data   = '0;
  endtask

  task automatic set_rd(input int p, input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] v);
    rd_addr[p*REG_ADDR_W +: REG_ADDR_W] = a;
    rd_val_in[p*XLEN +: XLEN]           = v;
  endtask

  task automatic set_src(input int s, input logic en, input logic [REG_ADDR_W-1:0] r,
                         input logic ok, input logic [XLEN-1:0] d);
    fwd_wb_en[s]                       = en;
    fwd_rd[s*REG_ADDR_W +: REG_ADDR_W] = r;
    fwd_data_ok[s]                     = ok;
    fwd_data[s*XLEN +: XLEN]           = d;
  endtask

  task automatic issue(input logic lng, input logic [REG_ADDR_W-1:0] r);
    issue_valid = 1'b1;
    issue_long  = lng;
    issue_rd    = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_busy   = '0;
    m_pend   = 0;
    m_stalls = '0;
  endtask

  // Expected operands and stall from the forwarding rules and current model state.
  task automatic model_eval();
    logic [REG_ADDR_W-1:0] a;
    bit found;
    bit haz;
    exp_stall = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      a          = rd_addr[p*REG_ADDR_W +: REG_ADDR_W];
      exp_val[p] = rd_val_in[p*XLEN +: XLEN];
      haz        = 1'b0;
      found      = 1'b0;
      if (a != 0) begin
        for (int s = 0; s < NUM_FWD; s++) begin
          if (!found && fwd_wb_en[s] && fwd_rd[s*REG_ADDR_W +: REG_ADDR_W] == a) begin
            found      = 1'b1;
            exp_val[p] = fwd_data[s*XLEN +: XLEN];
            haz        = !fwd_data_ok[s];
          end
        end
        if (!found) begin
          if (cmpl_valid && cmpl_rd == a) exp_val[p] = cmpl_data;
          else haz = m_busy[a];
        end
      end
      if (haz) exp_stall = 1'b1;
    end
    if (issue_valid && issue_long && m_pend == MAX_PEND && !cmpl_valid) exp_stall = 1'b1;
  endtask

  task automatic model_step();
    if (cmpl_valid && m_pend > 0) begin
      m_busy[cmpl_rd] = 1'b0;
      m_pend--;
    end
    if (issue_valid && !exp_stall && issue_long && issue_rd != 0) begin
      m_busy[issue_rd] = 1'b1;
      m_pend++;
    end
    if (exp_stall && m_stalls != 32'hFFFF_FFFF) m_stalls++;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    tests++; if (busy_map !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h expected %h", busy_map, 32'h0); end
    tests++; if (pend_cnt !== '0) begin fails++; $display("FAIL reset_pend: got %0d expected 0", pend_cnt); end
    tests++; if (stall_cycles !== 32'h0) begin fails++; $display("FAIL reset_stallcnt: got %0d expected 0", stall_cycles); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    do_reset();
    set_src(0, 1'b1, 5'd3, 1'b1, 32'hAAAA_AAAA);
    set_src(1, 1'b1, 5'd3, 1'b1, 32'hBBBB_BBBB);
    set_rd(0, 5'd3, 32'h1111_1111);
    set_rd(1, 5'd0, 32'h2222_2222);
    #2;
    tests++; if (out_port(0) !== 32'hAAAA_AAAA) begin fails++; $display("FAIL prio_youngest: got %h expected %h", out_port(0), 32'hAAAA_AAAA); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL prio_stall: got %b expected 0", stall); end
    tests++; if (out_port(1) !== 32'h2222_2222) begin fails++; $display("FAIL prio_x0_port: got %h expected %h", out_port(1), 32'h2222_2222); end
    fwd_wb_en[0] = 1'b0;
    #2;
    tests++; if (out_port(0) !== 32'hBBBB_BBBB) begin fails++; $display("FAIL prio_older: got %h expected %h", out_port(0), 32'hBBBB_BBBB); end
    fwd_wb_en = '0;
    #2;
    tests++; if (out_port(0) !== 32'h1111_1111) begin fails++; $display("FAIL prio_regfile: got %h expected %h", out_port(0), 32'h1111_1111); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_src(0, 1'b1, 5'd5, 1'b0, 32'h5555_0000);
    set_rd(0, 5'd5, 32'h0);
    #2;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b expected 1", stall); end
    next_cycle();
    fwd_data_ok[0] = 1'b1;
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_ready_stall: got %b expected 0", stall); end
    tests++; if (out_port(0) !== 32'h5555_0000) begin fails++; $display("FAIL load_ready_val: got %h expected %h", out_port(0), 32'h5555_0000); end
    tests++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL load_stallcnt: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_long_latency();
    do_reset();
    issue(1'b1, 5'd7);
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL long_issue_stall: got %b expected 0", stall); end
    next_cycle();
    idle();
    set_rd(0, 5'd7, 32'h7777_7777);
    #2;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL long_raw_stall: got %b expected 1", stall); end
    tests++; if (busy_map !== 32'h0000_0080) begin fails++; $display("FAIL long_busy: got %h expected %h", busy_map, 32'h80); end
    tests++; if (pend_cnt !== 3'd1) begin fails++; $display("FAIL long_pend: got %0d expected 1", pend_cnt); end
    next_cycle();
    cmpl_valid = 1'b1;
    cmpl_rd    = 5'd7;
    cmpl_data  = 32'h1234_5678;
    #2;
    tests++; if (out_port(0) !== 32'h1234_5678) begin fails++; $display("FAIL cmpl_fwd_val: got %h expected %h", out_port(0), 32'h1234_5678); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL cmpl_fwd_stall: got %b expected 0", stall); end
    tests++; if (busy_map !== 32'h0000_0080) begin fails++; $display("FAIL cmpl_busy_held: got %h expected %h", busy_map, 32'h80); end
    next_cycle();
    idle();
    #2;
    tests++; if (busy_map !== 32'h0) begin fails++; $display("FAIL cmpl_busy_clr: got %h expected 0", busy_map); end
    tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL cmpl_pend: got %0d expected 0", pend_cnt); end
    tests++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL long_stallcnt: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_pend_limit();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue(1'b1, REG_ADDR_W'(r));
      next_cycle();
    end
    issue(1'b1, 5'd5);
    #2;
    tests++; if (pend_cnt !== 3'd4) begin fails++; $display("FAIL full_pend: got %0d expected 4", pend_cnt); end
    tests++; if (busy_map !== 32'h0000_001E) begin fails++; $display("FAIL full_busy: got %h expected %h", busy_map, 32'h1E); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall: got %b expected 1", stall); end
    next_cycle();
    tests++; if (pend_cnt !== 3'd4) begin fails++; $display("FAIL full_hold_pend: got %0d expected 4", pend_cnt); end
    cmpl_valid = 1'b1;
    cmpl_rd    = 5'd1;
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL full_cmpl_stall: got %b expected 0", stall); end
    next_cycle();
    idle();
    #2;
    tests++; if (pend_cnt !== 3'd4) begin fails++; $display("FAIL swap_pend: got %0d expected 4", pend_cnt); end
    tests++; if (busy_map !== 32'h0000_003C) begin fails++; $display("FAIL swap_busy: got %h expected %h", busy_map, 32'h3C); end
    tests++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL full_stallcnt: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_x0();
    do_reset();
    issue(1'b1, 5'd0);
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_issue_stall: got %b expected 0", stall); end
    next_cycle();
    idle();
    set_src(0, 1'b1, 5'd0, 1'b0, 32'hDEAD_0000);
    set_src(1, 1'b1, 5'd0, 1'b1, 32'hDEAD_0001);
    cmpl_valid = 1'b1;
    cmpl_rd    = 5'd0;
    cmpl_data  = 32'hDEAD_0002;
    set_rd(0, 5'd0, 32'hC0DE_0000);
    set_rd(1, 5'd0, 32'hC0DE_0001);
    #2;
    tests++; if (busy_map !== 32'h0) begin fails++; $display("FAIL x0_busy: got %h expected 0", busy_map); end
    tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL x0_pend: got %0d expected 0", pend_cnt); end
    tests++; if (out_port(0) !== 32'hC0DE_0000) begin fails++; $display("FAIL x0_val0: got %h expected %h", out_port(0), 32'hC0DE_0000); end
    tests++; if (out_port(1) !== 32'hC0DE_0001) begin fails++; $display("FAIL x0_val1: got %h expected %h", out_port(1), 32'hC0DE_0001); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall: got %b expected 0", stall); end
    next_cycle();
    idle();
    #2;
    tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL x0_no_underflow: got %0d expected 0", pend_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(1'b1, 5'd8);
    next_cycle();
    issue(1'b1, 5'd9);
    next_cycle();
    idle();
    set_rd(0, 5'd8, 32'h0);
    next_cycle();
    idle();
    #1;
    tests++; if (pend_cnt !== 3'd2) begin fails++; $display("FAIL pre_rst_pend: got %0d expected 2", pend_cnt); end
    tests++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL pre_rst_stallcnt: got %0d expected 1", stall_cycles); end
    rst_n = 1'b0;
    #1;
    tests++; if (busy_map !== 32'h0) begin fails++; $display("FAIL async_rst_busy: got %h expected 0", busy_map); end
    tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL async_rst_pend: got %0d expected 0", pend_cnt); end
    tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL async_rst_stallcnt: got %0d expected 0", stall_cycles); end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      for (int p = 0; p < NUM_RD; p++)
        set_rd(p, REG_ADDR_W'($urandom_range(0, 7)), $urandom);
      for (int s = 0; s < NUM_FWD; s++)
        set_src(s, 1'($urandom_range(0, 2) == 0), REG_ADDR_W'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), $urandom);
      issue_valid = 1'($urandom_range(0, 1));
      issue_long  = 1'($urandom_range(0, 1));
      issue_rd    = REG_ADDR_W'($urandom_range(0, 7));
      cmpl_valid  = 1'($urandom_range(0, 3) == 0);
      cmpl_rd     = REG_ADDR_W'($urandom_range(0, 7));
      cmpl_data   = $urandom;
      #2;
      model_eval();
      for (int p = 0; p < NUM_RD; p++) begin
        tests++;
        if (out_port(p) !== exp_val[p]) begin
          fails++;
          $display("FAIL rand_val[%0d] cyc %0d: got %h expected %h", p, c, out_port(p), exp_val[p]);
        end
      end
      tests++; if (stall !== exp_stall) begin fails++; $display("FAIL rand_stall cyc %0d: got %b expected %b", c, stall, exp_stall); end
      tests++; if (busy_map !== m_busy) begin fails++; $display("FAIL rand_busy cyc %0d: got %h expected %h", c, busy_map, m_busy); end
      tests++; if (int'(pend_cnt) !== m_pend) begin fails++; $display("FAIL rand_pend cyc %0d: got %0d expected %0d", c, pend_cnt, m_pend); end
      tests++; if (stall_cycles !== m_stalls) begin fails++; $display("FAIL rand_stallcnt cyc %0d: got %0d expected %0d", c, stall_cycles, m_stalls); end
      model_step();
    end
    next_cycle();
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_long_latency();
    test_pend_limit();
    test_x0();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
